mmss_scan_display: RTL and testbench
====================================

Name: mmss_scan_display

Overview:
Downstream stage of the seconds counter. It takes the once-per-second tick and keeps a minutes:seconds BCD count from 00:00 to 59:59. It drives a 4-digit common-cathode 7-segment display by time-multiplexing the digits, with a blinking colon on the decimal point. Segment decode uses the team's seg7 decoder (4-bit BCD in, 7 segments out).

Parameters:
SCAN_DIV, 4, clock cycles per digit slot; must be >= 2. Slot cycle 0 is blank and cycles 1..SCAN_DIV-1 show the digit. At 1 kHz clk this gives about 62 Hz refresh.

Ports:
clk  input  1  system clock (1 kHz external clock)
reset  input  1  synchronous, active-low reset; sampled on posedge clk
tick  input  1  one-cycle pulse per second from the upstream seconds counter
pause  input  1  high: ignore tick; scanning continues
clear  input  1  synchronous count clear to 00:00
seg  output  7  segments, active-high; seg[0]=a … seg[6]=g
dig_n  output  4  digit enables, active-low; bit0=s0 (sec units), bit1=s1 (sec tens), bit2=m0 (min units), bit3=m1 (min tens)
dp  output  1  decimal point, active-high; used as the colon
rollover  output  1  one-cycle pulse on 59:59 -> 00:00

Behaviour:
- All state is updated on posedge clk. Nothing is asynchronous.
- Reset (reset==0 at the edge) sets:
  - s0, s1, m0, m1 to 0; colon_ph to 0; sel to 0; scan_cnt to 0
  - seg=0, dig_n=4'b1111, dp=0, rollover=0
- Reset asserted mid-scan or mid-count takes effect at that edge. No partial update occurs.
- Count priority: reset > clear > (tick & ~pause).
- clear: all digits go to 0 and colon_ph to 0. rollover=0 even if tick is high in the same cycle.
- Accepted tick (tick & ~pause & ~clear): the count increments once, visible the next cycle. colon_ph toggles.
  - s0: 0-9, wraps to 0 and carries to s1.
  - s1: 0-5, wraps to 0 and carries to m0.
  - m0: 0-9, wraps to 0 and carries to m1.
  - m1: 0-5, wraps to 0.
- Full wrap 59:59 -> 00:00: rollover=1 for exactly the cycle after the accepting edge. Otherwise rollover=0.
- tick held high for N cycles counts N times; there is no edge detection, because upstream guarantees single-cycle pulses.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At scan_cnt==SCAN_DIV-1: scan_cnt goes to 0 and sel goes to (sel+1) mod 4.
  - Sequence is s0 -> s1 -> m0 -> m1 -> s0.
  - Scanning is independent of pause, clear and tick.
- Outputs are registered, computed from the pre-edge values of sel, scan_cnt, digits and colon_ph.
  - If scan_cnt==0 (blank slot): seg=0, dig_n=4'b1111, dp=0.
  - Otherwise: dig_n has a single 0 at bit sel; seg=seg7(digit[sel]); dp = colon_ph & (sel==2).
- Display latency: an output reflects state one cycle old. A digit change during a slot appears on the following cycle. No latching per slot.
- Only one dig_n bit is ever low. A blank cycle separates every digit change (anti-ghosting).
- Digit values never exceed their range. Out-of-range states are unreachable and need no handling.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with tick=1 -> seg=0, dig_n=1111, dp=0, rollover=0, count 00:00. After release, the first shown slot is dig_n=1110 with seg=7'b0111111 ("0").
2. Scan, SCAN_DIV=4: free-run 16 cycles after reset -> dig_n sequence is 1111, 1110×3, 1111, 1101×3, 1111, 1011×3, 1111, 0111×3, then it repeats.
3. Counting: 10 ticks spaced 5 cycles apart -> after the 9th, s0=9 and s1=0. After the 10th, s0=0 and s1=1. With s0=5, its slot shows seg=7'b1101101.
4. Wrap: 3599 ticks -> 59:59, rollover never high. The next tick -> 00:00 with rollover=1 for exactly one cycle. colon_ph then equals 0 (3600 toggles).
5. Controls:
   - pause=1 with 5 ticks -> count unchanged, scanning unaffected.
   - clear=1 and tick=1 in the same cycle at 12:34 -> 00:00, rollover=0, dp low in the m0 slot.
6. Reset mid-operation: at 07:42, mid-slot for m0, pulse reset=0 for 1 cycle -> the next cycle is blank with count 00:00, sel restarts at s0, rollover=0.

Source files
------------

// File: rtl/mmss_scan_display.sv
// mm:ss BCD clock with a multiplexed 4-digit 7-segment display.
// Colon blinks on the m0 decimal point; blank cycle between digits.
module mmss_scan_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       pause,
  input  logic       clear,
  output logic [6:0] seg,
  output logic [3:0] dig_n,
  output logic       dp,
  output logic       rollover
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [3:0]    s0_q, s0_d, s1_q, s1_d;
  logic [3:0]    m0_q, m0_d, m1_q, m1_d;
  logic          colon_q, colon_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_n_q, dig_n_d;
  logic          dp_q, dp_d;
  logic          roll_q, roll_d;
  logic [3:0]    cur_dig;

  // BCD digit to segments, a in bit 0 .. g in bit 6
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // Time count: clear wins over an accepted tick
  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    m0_d    = m0_q;
    m1_d    = m1_q;
    colon_d = colon_q;
    roll_d  = 1'b0;
    if (clear) begin
      s0_d    = 4'd0;
      s1_d    = 4'd0;
      m0_d    = 4'd0;
      m1_d    = 4'd0;
      colon_d = 1'b0;
    end else if (tick && !pause) begin
      colon_d = ~colon_q;
      roll_d  = (s0_q == 4'd9) && (s1_q == 4'd5) &&
                (m0_q == 4'd9) && (m1_q == 4'd5);
      if (s0_q != 4'd9) begin
        s0_d = s0_q + 4'd1;
      end else begin
        s0_d = 4'd0;
        if (s1_q != 4'd5) begin
          s1_d = s1_q + 4'd1;
        end else begin
          s1_d = 4'd0;
          if (m0_q != 4'd9) begin
            m0_d = m0_q + 4'd1;
          end else begin
            m0_d = 4'd0;
            m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
          end
        end
      end
    end
  end

  // Free-running scan: slot counter and digit select
  always_comb begin
    scan_cnt_d = scan_cnt_q + CW'(1);
    sel_d      = sel_q;
    if (scan_cnt_q == CNT_MAX) begin
      scan_cnt_d = '0;
      sel_d      = sel_q + 2'd1;
    end
  end

  // Pick the digit for the current slot
  always_comb begin
    case (sel_q)
      2'd0:    cur_dig = s0_q;
      2'd1:    cur_dig = s1_q;
      2'd2:    cur_dig = m0_q;
      default: cur_dig = m1_q;
    endcase
  end

  // Display drive; slot cycle 0 is blank to avoid ghosting
  always_comb begin
    seg_d   = 7'd0;
    dig_n_d = 4'b1111;
    dp_d    = 1'b0;
    if (scan_cnt_q != '0) begin
      dig_n_d = ~(4'b0001 << sel_q);
      seg_d   = seg7(cur_dig);
      dp_d    = colon_q && (sel_q == 2'd2);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      s0_q       <= 4'd0;
      s1_q       <= 4'd0;
      m0_q       <= 4'd0;
      m1_q       <= 4'd0;
      colon_q    <= 1'b0;
      sel_q      <= 2'd0;
      scan_cnt_q <= '0;
      seg_q      <= 7'd0;
      dig_n_q    <= 4'b1111;
      dp_q       <= 1'b0;
      roll_q     <= 1'b0;
    end else begin
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      m0_q       <= m0_d;
      m1_q       <= m1_d;
      colon_q    <= colon_d;
      sel_q      <= sel_d;
      scan_cnt_q <= scan_cnt_d;
      seg_q      <= seg_d;
      dig_n_q    <= dig_n_d;
      dp_q       <= dp_d;
      roll_q     <= roll_d;
    end
  end

  assign seg      = seg_q;
  assign dig_n    = dig_n_q;
  assign dp       = dp_q;
  assign rollover = roll_q;

endmodule

// File: tb/tb_mmss_scan_display.sv
// Bench for mmss_scan_display: randomized ticks against a
// seconds-based reference model of count and scan position.
module tb_mmss_scan_display;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset, tick, pause, clear;
  logic [6:0] seg;
  logic [3:0] dig_n;
  logic       dp, rollover;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: total seconds, colon phase, cycle-in-frame
  int m_secs = 0;
  bit m_col = 1'b0;
  int m_ph = 0;
  int e_dv = 0;
  logic [6:0] e_seg;
  logic [3:0] e_dig;
  logic       e_dp, e_ro;

  logic [6:0] font [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  mmss_scan_display #(.SCAN_DIV(D)) dut (
    .clk(clk), .reset(reset), .tick(tick), .pause(pause),
    .clear(clear), .seg(seg), .dig_n(dig_n), .dp(dp),
    .rollover(rollover)
  );

  always #5 clk = ~clk;

  // Drive one cycle, predict outputs, sample 1 time unit after the edge
  task automatic step(input logic tk, pa, cl, rs);
    int cnt, sl;
    tick = tk; pause = pa; clear = cl; reset = rs;
    e_seg = 7'd0; e_dig = 4'hF; e_dp = 1'b0; e_ro = 1'b0;
    if (!rs) begin
      m_secs = 0; m_col = 1'b0; m_ph = 0;
    end else begin
      cnt = m_ph % D;
      sl  = m_ph / D;
      case (sl)
        0: e_dv = m_secs % 10;
        1: e_dv = (m_secs / 10) % 6;
        2: e_dv = (m_secs / 60) % 10;
        default: e_dv = m_secs / 600;
      endcase
      if (cnt != 0) begin
        e_dig[sl] = 1'b0;
        e_seg = font[e_dv];
        e_dp = m_col && (sl == 2);
      end
      if (cl) begin
        m_secs = 0; m_col = 1'b0;
      end else if (tk && !pa) begin
        if (m_secs == 3599) e_ro = 1'b1;
        m_secs = (m_secs + 1) % 3600;
        m_col = !m_col;
      end
      m_ph = (m_ph + 1) % (4 * D);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0);
      n_chk++;
      if ({seg, dig_n, dp, rollover} !== {7'd0, 4'hF, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold: got %b %b %b %b want 0000000 1111 0 0",
                 seg, dig_n, dp, rollover);
      end
    end
    step(0, 0, 0, 1);
    n_chk++;
    if ({seg, dig_n, dp} !== {7'd0, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_first_blank: got %b %b %b", seg, dig_n, dp);
    end
    step(0, 0, 0, 1);
    n_chk++;
    if ({seg, dig_n, dp} !== {7'b0111111, 4'b1110, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_first_digit: got %b %b %b want 0111111 1110 0",
               seg, dig_n, dp);
    end
  endtask

  task automatic test_scan();
    logic [3:0] want;
    step(0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 1);
      want = 4'hF;
      if (i % 4 != 0) want[(i % 16) / 4] = 1'b0;
      n_chk++;
      if (dig_n !== want || seg !== e_seg) begin
        n_fail++;
        $display("FAIL scan[%0d]: got dig_n=%b seg=%b want %b %b",
                 i, dig_n, seg, want, e_seg);
      end
    end
  endtask

  task automatic test_count();
    step(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 5; j++) begin
        step(j == 0, 0, 0, 1);
        n_chk++;
        if ({seg, dig_n, dp, rollover} !== {e_seg, e_dig, e_dp, e_ro}) begin
          n_fail++;
          $display("FAIL count: got %b %b %b %b want %b %b %b %b",
                   seg, dig_n, dp, rollover, e_seg, e_dig, e_dp, e_ro);
        end
        if (e_dv == 5 && e_dig == 4'b1110) begin
          n_chk++;
          if (seg !== 7'b1101101) begin
            n_fail++;
            $display("FAIL count_s0_5: got %b want 1101101", seg);
          end
        end
      end
    end
    for (int j = 0; j < 16; j++) begin
      step(0, 0, 0, 1);
      if (dig_n == 4'b1101 || dig_n == 4'b1110) begin
        n_chk++;
        if (seg !== (dig_n == 4'b1101 ? 7'b0000110 : 7'b0111111)) begin
          n_fail++;
          $display("FAIL count_10: dig_n=%b got seg=%b", dig_n, seg);
        end
      end
    end
  endtask

  task automatic test_wrap();
    step(0, 0, 0, 0);
    for (int i = 0; i < 3599; i++) begin
      step(1, 0, 0, 1);
      n_chk++;
      if ({seg, dig_n, dp, rollover} !== {e_seg, e_dig, e_dp, 1'b0}) begin
        n_fail++;
        $display("FAIL wrap_run: got %b %b %b %b want %b %b %b 0",
                 seg, dig_n, dp, rollover, e_seg, e_dig, e_dp);
      end
      if ($urandom_range(0, 1) == 1) step(0, 0, 0, 1);
    end
    step(1, 0, 0, 1);
    n_chk++;
    if (rollover !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_pulse: got rollover=%b want 1", rollover);
    end
    for (int j = 0; j < 16; j++) begin
      step(0, 0, 0, 1);
      n_chk++;
      if ({seg, dig_n, dp, rollover} !== {e_seg, e_dig, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL wrap_after: got %b %b %b %b want %b %b 0 0",
                 seg, dig_n, dp, rollover, e_seg, e_dig);
      end
    end
  endtask

  task automatic test_controls();
    step(0, 0, 0, 0);
    for (int i = 0; i < 754; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(i % 2 == 0, 1, 0, 1);
      n_chk++;
      if ({seg, dig_n, dp, rollover} !== {e_seg, e_dig, e_dp, e_ro}) begin
        n_fail++;
        $display("FAIL pause: got %b %b %b %b want %b %b %b %b",
                 seg, dig_n, dp, rollover, e_seg, e_dig, e_dp, e_ro);
      end
    end
    step(1, 0, 1, 1);
    n_chk++;
    if (rollover !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ro: got rollover=%b want 0", rollover);
    end
    for (int j = 0; j < 16; j++) begin
      step(0, 0, 0, 1);
      n_chk++;
      if ({seg, dig_n, dp} !== {e_seg, e_dig, 1'b0} ||
          (e_dig != 4'hF && seg !== 7'b0111111)) begin
        n_fail++;
        $display("FAIL clear_view: got %b %b %b want %b %b 0",
                 seg, dig_n, dp, e_seg, e_dig);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    step(0, 0, 0, 0);
    for (int i = 0; i < 462; i++) step(1, 0, 0, 1);
    guard = 0;
    while (m_ph != 2 * D + 2 && guard < 64) begin
      step(0, 0, 0, 1);
      guard++;
    end
    n_chk++;
    if (guard >= 64) begin
      n_fail++;
      $display("FAIL reset_mid_align: phase=%0d want %0d", m_ph, 2 * D + 2);
    end
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    n_chk++;
    if ({seg, dig_n, dp, rollover} !== {7'd0, 4'hF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_blank: got %b %b %b %b", seg, dig_n, dp, rollover);
    end
    step(0, 0, 0, 1);
    n_chk++;
    if ({seg, dig_n, dp} !== {7'b0000110, 4'b1110, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_s0: got %b %b %b want 0000110 1110 0",
               seg, dig_n, dp);
    end
  endtask

  task automatic test_random();
    logic tk, pa, cl, rs;
    for (int i = 0; i < 3000; i++) begin
      tk = ($urandom_range(0, 2) == 0);
      pa = ($urandom_range(0, 5) == 0);
      cl = ($urandom_range(0, 99) == 0);
      rs = ($urandom_range(0, 299) != 0);
      step(tk, pa, cl, rs);
      n_chk++;
      if ({seg, dig_n, dp, rollover} !== {e_seg, e_dig, e_dp, e_ro}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b %b %b %b want %b %b %b %b",
                 i, seg, dig_n, dp, rollover, e_seg, e_dig, e_dp, e_ro);
      end
    end
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; pause = 1'b0; clear = 1'b0;
    test_reset();
    test_scan();
    test_count();
    test_wrap();
    test_controls();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
